// File: rtl/input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// input_debounce_pkg
//   Shared definitions for the input_debounce block:
//     - state_e : debounce FSM state encoding (2-bit, STABLE_LOW = 0)
//     - sat_inc : saturating increment used by the optional glitch counter
// -----------------------------------------------------------------------------
package input_debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } state_e;

    // Increment value, holding at 2**width-1. Supports counter widths up to 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : (value + 32'd1);
    endfunction

endpackage

// File: rtl/input_debounce_sync_ff.sv
// -----------------------------------------------------------------------------
// input_debounce_sync_ff
//   STAGES-deep flop chain bringing an asynchronous pin into the clk domain.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous reset, active-high (all flops load RESET_VAL)
//     d    in   raw asynchronous input
//     q    out  synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module input_debounce_sync_ff #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//   Synchronises a raw pin, rejects bounce/glitches shorter than
//   DEBOUNCE_CYCLES synchronised samples and produces a clean level plus
//   single-cycle rise/fall strobes.
//   Ports:
//     clk         in   system clock
//     rst         in   synchronous reset, active-high
//     din         in   raw asynchronous pin
//     dout        out  debounced level
//     rise        out  1-cycle strobe on dout 0->1
//     fall        out  1-cycle strobe on dout 1->0
//     glitch_cnt  out  saturating count of aborted transitions
//   Build option:
//     DEBOUNCE_GLITCH_CNT_EN  defined   -> glitch counter built (saturates)
//                             undefined -> glitch_cnt tied to 0
// -----------------------------------------------------------------------------
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16,
    parameter int INVERT          = 0,
    parameter int GLITCH_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    output logic                dout,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               IMMEDIATE = (DEBOUNCE_CYCLES == 1);
    localparam bit               INV       = (INVERT != 0);

    logic sync_out;
    logic s;

    // The chain resets to the raw level that reads as 0 after inversion, so a
    // pin already sitting at the active level still needs the full
    // synchroniser + debounce latency before the first rise.
    input_debounce_sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (INV)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync_out)
    );

    assign s = sync_out ^ INV;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    if (IMMEDIATE) begin
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                        state_d = STABLE_HIGH;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = CHECK_HIGH;
                    end
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    cnt_d   = '0;
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                    state_d = STABLE_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    if (IMMEDIATE) begin
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                        state_d = STABLE_LOW;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = CHECK_LOW;
                    end
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    cnt_d   = '0;
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                    state_d = STABLE_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic                glitch_evt;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    // An abort is any CHECK state seeing the old level again.
    assign glitch_evt = ((state_q == CHECK_HIGH) && !s) ||
                        ((state_q == CHECK_LOW)  &&  s);

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_evt) begin
            glitch_d = GLITCH_W'(sat_inc(32'(glitch_q), GLITCH_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

    localparam int GW = 4;

    logic          clk;
    logic          rst_a, din_a, dout_a, rise_a, fall_a;
    logic [GW-1:0] glitch_a;
    logic          rst_b, din_b, dout_b, rise_b, fall_b;
    logic [GW-1:0] glitch_b;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16),
        .INVERT          (0),
        .GLITCH_W        (GW)
    ) dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .din        (din_a),
        .dout       (dout_a),
        .rise       (rise_a),
        .fall       (fall_a),
        .glitch_cnt (glitch_a)
    );

    input_debounce #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (16),
        .INVERT          (1),
        .GLITCH_W        (GW)
    ) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .din        (din_b),
        .dout       (dout_b),
        .rise       (rise_b),
        .fall       (fall_b),
        .glitch_cnt (glitch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so inputs/outputs are away from it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] exp_glitch(input int events);
        int v;
        v = (events > 15) ? 15 : events;
        return GLITCH_EN ? 32'(v) : 32'd0;
    endfunction

    int  rises, falls, both, toggles, up_toggles;
    logic prev_dout;
    bit   saw;

    initial begin
        rst_a = 1'b1; din_a = 1'b0;
        rst_b = 1'b1; din_b = 1'b0;
        tick(3);
        check("reset_dout", dout_a, 0);
        check("reset_strobes", {rise_a, fall_a}, 0);
        check("reset_glitch", glitch_a, 0);
        rst_a = 1'b0;
        tick(3);

        // 1. Clean edges
        din_a = 1'b1;
        tick(5);
        check("clean_rise_e5_dout", dout_a, 0);
        check("clean_rise_e5_rise", rise_a, 0);
        tick();
        check("clean_rise_e6_dout", dout_a, 1);
        check("clean_rise_e6_rise", rise_a, 1);
        tick();
        check("clean_rise_e7_rise", rise_a, 0);
        check("clean_rise_e7_dout", dout_a, 1);
        tick(3);
        din_a = 1'b0;
        tick(5);
        check("clean_fall_e5_dout", dout_a, 1);
        tick();
        check("clean_fall_e6_dout", dout_a, 0);
        check("clean_fall_e6_fall", fall_a, 1);
        check("clean_fall_e6_rise", rise_a, 0);
        tick();
        check("clean_fall_e7_fall", fall_a, 0);
        tick(3);

        // 2. Bounce: high 3, low 1, then high steady
        saw = 1'b0;
        din_a = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); saw |= rise_a; end
        din_a = 1'b0;
        tick(); saw |= rise_a;
        din_a = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); saw |= rise_a; end
        check("bounce_no_early_rise", saw, 0);
        tick();
        check("bounce_rise_e6", rise_a, 1);
        check("bounce_dout_e6", dout_a, 1);
        check("bounce_glitch", glitch_a, exp_glitch(1));
        din_a = 1'b0;
        tick(8);
        check("bounce_return_low", dout_a, 0);

        // 3. 20 two-cycle pulses: every one aborts; 21 events total saturate at 15
        saw = 1'b0;
        for (int p = 0; p < 20; p++) begin
            din_a = 1'b1;
            tick(); saw |= dout_a;
            tick(); saw |= dout_a;
            din_a = 1'b0;
            tick(); saw |= dout_a;
            tick(); saw |= dout_a;
            if (p == 4) check("pulses_glitch_mid", glitch_a, exp_glitch(5));
        end
        tick(4); saw |= dout_a;
        check("pulses_dout_low", saw, 0);
        check("pulses_glitch_sat", glitch_a, exp_glitch(21));

        // 4. Reset mid-CHECK
        din_a = 1'b1;
        tick(3);
        rst_a = 1'b1;
        tick();
        check("midrst_outputs", {dout_a, rise_a, fall_a}, 0);
        check("midrst_glitch", glitch_a, 0);
        rst_a = 1'b0;
        tick(5);
        check("midrst_e5_rise", rise_a, 0);
        tick();
        check("midrst_e6_rise", rise_a, 1);
        check("midrst_e6_dout", dout_a, 1);

        // 5. INVERT=1, DEBOUNCE_CYCLES=1, pin held low
        rst_b = 1'b0;
        tick();
        check("inv_e1_dout", dout_b, 0);
        tick();
        check("inv_e2_dout", dout_b, 0);
        check("inv_e2_rise", rise_b, 0);
        tick();
        check("inv_e3_dout", dout_b, 1);
        check("inv_e3_rise", rise_b, 1);
        rises = 0;
        for (int i = 0; i < 10; i++) begin tick(); rises += int'(rise_b | fall_b); end
        check("inv_single_rise", rises, 0);
        check("inv_dout_held", dout_b, 1);

        // 6. Random pin with occasional changes
        rises = 0; falls = 0; both = 0; toggles = 0; up_toggles = 0;
        prev_dout = dout_a;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0) din_a = ~din_a;
            tick();
            rises += int'(rise_a);
            falls += int'(fall_a);
            both  += int'(rise_a & fall_a);
            if (dout_a != prev_dout) begin
                toggles++;
                if (dout_a) up_toggles++;
            end
            prev_dout = dout_a;
        end
        check("rand_both_high", both, 0);
        check("rand_strobes_vs_toggles", rises + falls, toggles);
        check("rand_rise_vs_up", rises, up_toggles);
        check("rand_active", toggles != 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
